pipe_stage_skid: RTL
====================

PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning payload width in bits.
REQ-002 SHALL have parameter NOP_VALUE, default 32'h00000020 (add r0,r0,r0) zero-extended or truncated to WIDTH, meaning payload shown when the stage is empty.
REQ-003 SHALL have parameter KEEP_MASK, default 0, WIDTH bits, meaning payload bits that hold their last value across flush/empty instead of taking NOP_VALUE.
REQ-004 SHALL have port clk  input  1  clock; all state updates on posedge clk.
REQ-005 SHALL have port rst  input  1  synchronous active-high reset.
REQ-006 SHALL have port flush  input  1  discard all held entries.
REQ-007 SHALL have port stall  input  1  freeze both sides of the stage.
REQ-008 SHALL have port in_valid  input  1  upstream entry present.
REQ-009 SHALL have port in_ready  output  1  stage can accept this cycle.
REQ-010 SHALL have port in_data  input  WIDTH  upstream payload.
REQ-011 SHALL have port out_valid  output  1  downstream entry present.
REQ-012 SHALL have port out_ready  input  1  downstream accepts this cycle.
REQ-013 SHALL have port out_data  output  WIDTH  downstream payload.
REQ-014 SHALL have port occupancy  output  2  entries held, 0..2.

Function
REQ-015 SHALL hold two entries: main (drives out_data) and skid (catches one word when downstream stops).
REQ-016 in_ready SHALL equal !skid_valid && !stall && !flush, derived from registered state plus stall/flush only, never from out_ready.
REQ-017 Input transfer SHALL occur when in_valid && in_ready; output transfer when out_valid && out_ready && !stall && !flush.
REQ-018 out_valid SHALL equal main_valid; out_data SHALL equal main payload when main_valid.
REQ-019 When main is empty, out_data SHALL equal (NOP_VALUE & ~KEEP_MASK) | (last main payload & KEEP_MASK).
REQ-020 Latency SHALL be one cycle: a word accepted into an empty stage appears on out_data the next cycle.
REQ-021 Input transfer with main empty, or with main delivering this cycle and skid empty, SHALL load main.
REQ-022 Input transfer with main full and not delivering SHALL load skid.
REQ-023 Output transfer with skid full SHALL move skid to main and empty skid in the same edge.
REQ-024 Simultaneous input and output transfer with skid empty SHALL replace main, occupancy unchanged.
REQ-025 Order SHALL be preserved: words leave in acceptance order; no word duplicated or dropped except by flush.
REQ-026 stall SHALL hold all state, including occupancy and out_data; out_valid remains asserted if set.
REQ-027 flush SHALL have priority over stall and both transfers: next edge both entries empty, occupancy 0, in_data not captured.
REQ-028 On flush, KEEP_MASK bits of out_data SHALL retain the main payload value present at the flush edge.
REQ-029 occupancy SHALL equal main_valid + skid_valid, registered.

Reset
REQ-030 rst SHALL override flush, stall and all transfers.
REQ-031 After rst: main_valid=0, skid_valid=0, occupancy=0, out_valid=0, in_ready=1 (when stall=0, flush=0), out_data=NOP_VALUE including KEEP_MASK bits.
REQ-032 rst asserted mid-transfer SHALL discard held entries without emitting them.

Structure
REQ-033 Default NOP encoding and the default WIDTH SHALL live in the shared CPU package, used by all pipeline stages.
REQ-034 No sub-module is required; main/skid datapath and control SHALL be a single module.

Verification
REQ-035 Reset then in_valid=1, in_data=0x1234, out_ready=1 -> next cycle out_valid=1, out_data=0x1234, occupancy=1.
REQ-036 Feed 0xA,0xB,0xC back-to-back, out_ready=0 on cycle 2 -> 0xB held in skid, in_ready=0, occupancy=2; release -> out sequence 0xA,0xB,0xC, none lost.
REQ-037 Occupancy 2, flush=1 with in_valid=1, stall=1 -> next cycle occupancy=0, out_valid=0, out_data=0x00000020, in_data not captured.
REQ-038 KEEP_MASK=0xFFFF0000, main=0xBEEF1234, flush -> out_data=0xBEEF0020.
REQ-039 Occupancy 1, stall=1 for 3 cycles with out_ready=1, in_valid=1 -> out_data/occupancy unchanged, in_ready=0, no transfer.
REQ-040 Occupancy 2, rst=1 with flush=0, out_ready=1 -> next cycle occupancy=0, out_valid=0, held words never appear on output.

Source files
------------

// File: rtl/pipe_stage_skid_pkg.sv
// Shared CPU pipeline definitions: default datapath width and the NOP shown by empty stages.
package pipe_stage_skid_pkg;

  localparam int unsigned CPU_XLEN = 32;
  // add r0,r0,r0
  localparam logic [31:0] CPU_NOP  = 32'h0000_0020;

endpackage

// File: rtl/pipe_stage_skid.sv
// Two-entry (main + skid) pipeline register stage with stall, flush and NOP fill when empty.
module pipe_stage_skid
  import pipe_stage_skid_pkg::*;
#(
  parameter int unsigned      WIDTH     = CPU_XLEN,
  parameter logic [WIDTH-1:0] NOP_VALUE = WIDTH'(CPU_NOP),
  parameter logic [WIDTH-1:0] KEEP_MASK = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             stall,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);

  logic             main_valid, skid_valid;
  logic [WIDTH-1:0] main_data, skid_data;
  logic             main_valid_n, skid_valid_n;
  logic [WIDTH-1:0] main_data_n, skid_data_n;
  logic             in_xfer, out_xfer;

  assign in_ready  = !skid_valid && !stall && !flush;
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = main_valid && out_ready && !stall && !flush;

  assign out_valid = main_valid;
  // main_data is never cleared on empty, so it doubles as the "last payload" for KEEP_MASK bits
  assign out_data  = main_valid ? main_data
                                : ((NOP_VALUE & ~KEEP_MASK) | (main_data & KEEP_MASK));

  always_comb begin
    main_valid_n = main_valid;
    main_data_n  = main_data;
    skid_valid_n = skid_valid;
    skid_data_n  = skid_data;
    if (flush) begin
      main_valid_n = 1'b0;
      skid_valid_n = 1'b0;
    end else if (!stall) begin
      if (out_xfer) begin
        if (skid_valid) begin
          main_data_n  = skid_data;
          skid_valid_n = 1'b0;
        end else if (in_xfer) begin
          main_data_n  = in_data;
        end else begin
          main_valid_n = 1'b0;
        end
      end else if (in_xfer) begin
        if (!main_valid) begin
          main_valid_n = 1'b1;
          main_data_n  = in_data;
        end else begin
          skid_valid_n = 1'b1;
          skid_data_n  = in_data;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_data  <= NOP_VALUE;
      skid_data  <= '0;
      occupancy  <= '0;
    end else begin
      main_valid <= main_valid_n;
      skid_valid <= skid_valid_n;
      main_data  <= main_data_n;
      skid_data  <= skid_data_n;
      occupancy  <= 2'(main_valid_n) + 2'(skid_valid_n);
    end
  end

endmodule
